fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares a single sync_fifo write port between NUM_REQ producers. Each cycle it selects one eligible requester, registers that requester's data and a one-cycle write strobe toward the FIFO, and returns a one-hot grant pulse. A credit check based on fifo_cnt and the in-flight write keeps it from pushing into a full FIFO. It sits directly in front of the FIFO's wr/data_in pins; the read side of the FIFO is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 8, data width; must match the FIFO data_in width
FIFO_DEPTH, 8, FIFO capacity in entries
CNT_W, 4, width of fifo_cnt; must satisfy 2^CNT_W > FIFO_DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  arbitration enable; 0 freezes new grants
req  in  NUM_REQ  per-producer request level, bit i = producer i
req_data  in  NUM_REQ*DATA_W  producer data, slice i = bits [i*DATA_W +: DATA_W]
fifo_full  in  1  FIFO full flag
fifo_cnt  in  CNT_W  FIFO occupancy
fifo_wr  out  1  registered write strobe to the FIFO
fifo_data_in  out  DATA_W  registered write data to the FIFO
gnt  out  NUM_REQ  registered one-hot grant, high in the same cycle as fifo_wr
last_gnt  out  log2(NUM_REQ)  index of the most recent winner

Behaviour:
- Reset (rst=1 at an edge): fifo_wr=0, gnt=0, fifo_data_in=0, last_gnt=NUM_REQ-1, so producer 0 wins first. Reset mid-burst drops any pending selection. No write is emitted in the cycle after reset.
- Space check, evaluated each cycle: space = !fifo_full && (fifo_cnt + fifo_wr) < FIFO_DEPTH, with the sum computed at CNT_W+1 bits.
  - The check is conservative: concurrent FIFO reads are ignored.
  - It is therefore safe against the one-cycle lag of the registered fifo_wr.
- Eligibility: elig = req & ~gnt. A producer granted at edge k is masked at edge k+1, so one held request is never accepted twice. A lone producer therefore gets at most one write every 2 cycles.
- Arbitration at each rising edge, when en && space && |elig:
  - winner = first set bit of elig scanning (last_gnt+1) mod NUM_REQ upward, with wrap-around.
  - Registered updates: fifo_wr<=1, gnt<=onehot(winner), fifo_data_in<=req_data[winner], last_gnt<=winner.
- Otherwise at the edge: fifo_wr<=0, gnt<=0. fifo_data_in and last_gnt hold their values.
- Latency: data sampled at edge k appears on fifo_data_in with fifo_wr=1 during cycle k+1. The FIFO captures it at edge k+1.
- Producer protocol:
  - Hold req and req_data stable until gnt[i] is seen.
  - During the gnt cycle, the producer may drop req or present new data for its next request.
  - Dropping req before a grant withdraws the request silently.
- Fairness: with all producers requesting continuously, the grant order is 0,1,2,3,0,... and every producer waits at most NUM_REQ-1 grants.
- en=0: current outputs complete their single cycle, then no new grants issue. last_gnt holds.
- fifo_cnt > FIFO_DEPTH (illegal input): treated as no space.

Decomposition:
- Package fifo_arb_pkg holds:
  - DATA_W and FIFO_DEPTH defaults;
  - a CNT_W helper function (clog2(FIFO_DEPTH+1));
  - the index width function for NUM_REQ.
- Sub-module rr_pick (purely combinational): inputs elig and last_gnt; outputs onehot winner, winner index and a valid flag. It is reusable for a future read-side scheduler.
- Sequencing and registers stay in fifo_wr_arbiter.

Test Plan:
- Reset start, fifo_cnt=0, req=4'b0001, slice0=0x11 held:
  - fifo_wr=1 with fifo_data_in=0x11 on alternate cycles only.
  - gnt=0001 in each of those cycles.
- req=4'b1111 held, data 10,20,30,40 in slices 0..3, fifo_cnt held at 0:
  - grant sequence 0001,0010,0100,1000,0001 on consecutive cycles;
  - fifo_data_in sequence 10,20,30,40,10.
- fifo_cnt=7, req=4'b0010:
  - one write issues;
  - while fifo_cnt=7 and fifo_wr=1, the next cycle has no write;
  - fifo_cnt then forced to 8 with fifo_full=1 → fifo_wr stays 0 until fifo_cnt drops to 6.
- last_gnt=1, req=4'b1001 → producer 3 wins, then producer 0 (wrap-around).
- rst pulsed one cycle during continuous 4-way requests:
  - next cycle fifo_wr=0, gnt=0;
  - the first post-reset grant goes to producer 0.
- en=0 with req=4'b1111 for 5 cycles → no fifo_wr. Raise en → grants resume from last_gnt+1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults and width helpers for the FIFO write arbiter
// and its round-robin picker.
package fifo_arb_pkg;
   localparam int DATA_W_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 8;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; scans upward from last+1 with
// wrap-around and returns the first eligible index.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);
   always_comb begin
      int c;
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         c = (int'(last) + k) % N;
         if (!valid && elig[c]) begin
            valid = 1'b1;
            idx   = IW'(c);
         end
      end
      onehot = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sync_fifo write port among
// NUM_REQ producers, with a conservative credit check against overflow.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int CNT_W      = cnt_w(FIFO_DEPTH),
   localparam int IW        = idx_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      fifo_full,
   input  logic [CNT_W-1:0]          fifo_cnt,
   output logic                      fifo_wr,
   output logic [DATA_W-1:0]         fifo_data_in,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [IW-1:0]             last_gnt
);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
   logic [CNT_W:0]       sum;
   logic                 space, go, valid;
   logic [NUM_REQ-1:0]   elig, onehot;
   logic [IW-1:0]        idx;
   logic [DATA_W-1:0]    sel;
   // The in-flight write is counted as already occupying a slot; reads are ignored.
   assign sum   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, fifo_wr};
   assign space = !fifo_full && (sum < DEPTH_C);
   assign elig  = req & ~gnt;
   assign go    = en && space && valid;
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .elig   (elig),
      .last   (last_gnt),
      .onehot (onehot),
      .idx    (idx),
      .valid  (valid)
   );
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (onehot[i]) sel = req_data[i*DATA_W +: DATA_W];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wr      <= 1'b0;
         gnt          <= '0;
         fifo_data_in <= '0;
         last_gnt     <= IW'(NUM_REQ - 1);
      end else begin
         fifo_wr <= go;
         gnt     <= go ? onehot : '0;
         if (go) begin
            fifo_data_in <= sel;
            last_gnt     <= idx;
         end
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic, checked
// against a behavioural round-robin model.
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic          fifo_full = 1'b0;
   logic [3:0]    fifo_cnt = '0;
   logic          fifo_wr;
   logic [DW-1:0] fifo_data_in;
   logic [N-1:0]  gnt;
   logic [1:0]    last_gnt;
   int pass_cnt = 0;
   int total = 0;

   logic          m_wr = 1'b0;
   logic [N-1:0]  m_gnt = '0;
   logic [DW-1:0] m_data = '0;
   logic [1:0]    m_last = 2'd3;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
      .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .fifo_wr(fifo_wr),
      .fifo_data_in(fifo_data_in), .gnt(gnt), .last_gnt(last_gnt)
   );

   always #5 clk = ~clk;

   // Reference: scan producers in rotating priority order, skipping the one just granted.
   always @(posedge clk) begin : model
      int win, j;
      bit room;
      if (rst) begin
         m_wr <= 1'b0; m_gnt <= '0; m_data <= '0; m_last <= 2'd3;
      end else begin
         room = !fifo_full && (int'(fifo_cnt) + int'(m_wr) < DEPTH);
         win = -1;
         if (en && room)
            for (int off = 1; off <= N; off++) begin
               j = (int'(m_last) + off) % N;
               if (win < 0 && req[j] && !m_gnt[j]) win = j;
            end
         m_wr  <= (win >= 0);
         m_gnt <= (win >= 0) ? N'(1 << win) : '0;
         if (win >= 0) begin
            m_data <= req_data[win*DW +: DW];
            m_last <= 2'(win);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1; req = '0; en = 1'b1; fifo_full = 1'b0; fifo_cnt = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 4'b1111;
      tick(); tick();
      total++;
      if (fifo_wr !== 1'b0 || gnt !== 4'b0 || fifo_data_in !== 8'h00 || last_gnt !== 2'd3)
         $display("FAIL reset: wr=%b gnt=%b data=%h last=%0d, need 0 0000 00 3", fifo_wr, gnt, fifo_data_in, last_gnt);
      else pass_cnt++;
      rst = 1'b0; req = '0;
   endtask

   task automatic test_single;
      do_reset();
      req = 4'b0001; req_data = {24'h0, 8'h11};
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (fifo_wr !== 1'(i % 2 == 0))
            $display("FAIL single_alt cycle %0d: wr=%b, need %b", i, fifo_wr, 1'(i % 2 == 0));
         else pass_cnt++;
         if (i % 2 == 0) begin
            total++;
            if (gnt !== 4'b0001 || fifo_data_in !== 8'h11)
               $display("FAIL single_data cycle %0d: gnt=%b data=%h, need 0001 11", i, gnt, fifo_data_in);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [DW-1:0] ed [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
      do_reset();
      req = 4'b1111; req_data = {8'h40, 8'h30, 8'h20, 8'h10};
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (fifo_wr !== 1'b1 || gnt !== eg[i] || fifo_data_in !== ed[i])
            $display("FAIL rr step %0d: wr=%b gnt=%b data=%h, need 1 %b %h", i, fifo_wr, gnt, fifo_data_in, eg[i], ed[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_credit;
      do_reset();
      req = 4'b0010; req_data = {8'h0, 8'h0, 8'h5A, 8'h0}; fifo_cnt = 4'd7;
      tick();
      total++;
      if (fifo_wr !== 1'b1 || gnt !== 4'b0010 || fifo_data_in !== 8'h5A)
         $display("FAIL credit_first: wr=%b gnt=%b data=%h, need 1 0010 5a", fifo_wr, gnt, fifo_data_in);
      else pass_cnt++;
      tick();
      total++;
      if (fifo_wr !== 1'b0)
         $display("FAIL credit_inflight: wr=%b, need 0", fifo_wr);
      else pass_cnt++;
      fifo_cnt = 4'd8; fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (fifo_wr !== 1'b0)
            $display("FAIL credit_full cycle %0d: wr=%b, need 0", i, fifo_wr);
         else pass_cnt++;
      end
      fifo_cnt = 4'd6; fifo_full = 1'b0;
      tick();
      total++;
      if (fifo_wr !== 1'b1 || gnt !== 4'b0010)
         $display("FAIL credit_resume: wr=%b gnt=%b, need 1 0010", fifo_wr, gnt);
      else pass_cnt++;
      fifo_cnt = 4'd12;
      tick(); tick();
      total++;
      if (fifo_wr !== 1'b0)
         $display("FAIL credit_illegal_cnt: wr=%b, need 0", fifo_wr);
      else pass_cnt++;
      fifo_cnt = '0;
   endtask

   task automatic test_wrap;
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b1001;
      total++;
      if (last_gnt !== 2'd1)
         $display("FAIL wrap_setup: last=%0d, need 1", last_gnt);
      else pass_cnt++;
      tick();
      total++;
      if (gnt !== 4'b1000 || last_gnt !== 2'd3)
         $display("FAIL wrap_p3: gnt=%b last=%0d, need 1000 3", gnt, last_gnt);
      else pass_cnt++;
      tick();
      total++;
      if (gnt !== 4'b0001 || last_gnt !== 2'd0)
         $display("FAIL wrap_p0: gnt=%b last=%0d, need 0001 0", gnt, last_gnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      do_reset();
      req = 4'b1111;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (fifo_wr !== 1'b0 || gnt !== 4'b0)
         $display("FAIL reset_mid: wr=%b gnt=%b, need 0 0000", fifo_wr, gnt);
      else pass_cnt++;
      tick();
      total++;
      if (gnt !== 4'b0001)
         $display("FAIL reset_mid_first: gnt=%b, need 0001", gnt);
      else pass_cnt++;
   endtask

   task automatic test_enable;
      do_reset();
      req = 4'b1111;
      tick(); tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (fifo_wr !== 1'b0 || last_gnt !== 2'd1)
            $display("FAIL en_off cycle %0d: wr=%b last=%0d, need 0 1", i, fifo_wr, last_gnt);
         else pass_cnt++;
      end
      en = 1'b1;
      tick();
      total++;
      if (gnt !== 4'b0100 || fifo_wr !== 1'b1)
         $display("FAIL en_resume: gnt=%b wr=%b, need 0100 1", gnt, fifo_wr);
      else pass_cnt++;
   endtask

   task automatic test_random;
      int errs = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req = N'($urandom);
         req_data = {$urandom};
         fifo_cnt = 4'($urandom_range(10, 0));
         fifo_full = (fifo_cnt >= 4'(DEPTH)) || ($urandom_range(15, 0) == 0);
         en = ($urandom_range(7, 0) != 0);
         rst = ($urandom_range(49, 0) == 0);
         tick();
         total++;
         if (fifo_wr !== m_wr || gnt !== m_gnt || fifo_data_in !== m_data || last_gnt !== m_last) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random cycle %0d: wr=%b gnt=%b data=%h last=%0d, model %b %b %h %0d",
                        i, fifo_wr, gnt, fifo_data_in, last_gnt, m_wr, m_gnt, m_data, m_last);
         end else pass_cnt++;
      end
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_credit();
      test_wrap();
      test_reset_mid();
      test_enable();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
